sram_emu: RTL

SRAM_EMU -- requirements
Module: sram_emu

---
 rtl/sram_emu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sram_emu.sv
// Asynchronous-SRAM emulator: a chip-select/output-enable/write-enable bus
// with a modelled read access time, minimum write-pulse check and sticky error flags.
module sram_emu #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int RD_LAT = 2,
    parameter int WR_MIN = 1
) (
    input  logic              clka,
    input  logic              nrst,
    input  logic              nce,
    input  logic              noe,
    input  logic              nwe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_oe,
    output logic              dout_valid,
    input  logic              err_clr,
    output logic              err_short_wr,
    output logic              err_oob
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ACC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int WC_W   = $clog2(WR_MIN + 1) + 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_WAIT  = 2'd1;
    localparam logic [1:0] S_RD_VALID = 2'd2;
    localparam logic [1:0] S_WRITE    = 2'd3;

    localparam logic [ACC_W-1:0] ACC_LOAD = ACC_W'(RD_LAT - 1);
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [WC_W-1:0]  WC_MAX   = '1;
    localparam logic [WC_W:0]    WC_MIN_X = (WC_W+1)'(WR_MIN);

    logic [1:0]        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic              err_short_q, err_oob_q;
    logic              dout_oe_q;
    logic              fwd_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [DATA_W-1:0] rdata_q;

    logic              mem_we;
    logic              short_ev;
    logic              oob_ev;
    logic              pulse_ok;
    logic              wr_in_range;
    logic              rd_in_range;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    assign wr_in_range = in_range(wr_addr_q);
    assign rd_in_range = in_range(rd_addr_q);
    assign oob_ev      = ~nce & ~in_range(addr);
    // The commit edge itself is the last cycle of the pulse, so it counts too.
    assign pulse_ok    = ({1'b0, wcnt_q} + (WC_W+1)'(1)) >= WC_MIN_X;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wcnt_d    = wcnt_q;
        mem_we    = 1'b0;
        short_ev  = 1'b0;
        if (state_q == S_WRITE) begin
            if (nce || nwe) begin
                mem_we   = pulse_ok && wr_in_range;
                short_ev = !pulse_ok;
                if (!nce) begin
                    state_d   = S_RD_WAIT;
                    rd_addr_d = addr;
                    acc_d     = ACC_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                wr_addr_d = addr;
                wr_data_d = din;
                if (wcnt_q != WC_MAX) begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
        end else if (nce) begin
            state_d = S_IDLE;
        end else if (!nwe) begin
            state_d   = S_WRITE;
            wcnt_d    = '0;
            wr_addr_d = addr;
            wr_data_d = din;
        end else if (state_q == S_IDLE || addr != rd_addr_q) begin
            state_d   = S_RD_WAIT;
            rd_addr_d = addr;
            acc_d     = ACC_LOAD;
        end else if (state_q == S_RD_WAIT) begin
            if (acc_q == '0) begin
                state_d = S_RD_VALID;
            end else begin
                acc_d = acc_q - ACC_W'(1);
            end
        end
    end

    always_ff @(posedge clka or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wcnt_q      <= '0;
            err_short_q <= 1'b0;
            err_oob_q   <= 1'b0;
            dout_oe_q   <= 1'b0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wcnt_q      <= wcnt_d;
            err_short_q <= short_ev | (err_short_q & ~err_clr);
            err_oob_q   <= oob_ev | (err_oob_q & ~err_clr);
            dout_oe_q   <= ~nce & ~noe & nwe;
            // Read-first RAM returns stale data when a commit hits the word being latched.
            fwd_q       <= mem_we && (wr_addr_q == rd_addr_d);
            fwd_data_q  <= wr_data_q;
        end
    end

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;

    assign wr_idx = wr_addr_q[MEM_AW-1:0];
    assign rd_idx = rd_addr_d[MEM_AW-1:0];

    always_ff @(posedge clka) begin
        if (mem_we) begin
            mem[wr_idx] <= wr_data_q;
        end
        rdata_q <= mem[rd_idx];
    end

    assign dout_valid   = (state_q == S_RD_VALID);
    assign dout         = (dout_valid && rd_in_range) ? (fwd_q ? fwd_data_q : rdata_q) : '0;
    assign dout_oe      = dout_oe_q;
    assign err_short_wr = err_short_q;
    assign err_oob      = err_oob_q;

endmodule
